draw_triangle: RTL and testbench

DRAW_TRIANGLE -- requirements
Module: draw_triangle

---
 rtl/draw_triangle.sv | 124 ++++++++++++
 tb/tb_draw_triangle.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/draw_triangle.sv
// draw_triangle: walks the three edges of a clamped triangle, handing each
// non-degenerate edge to a downstream line rasterizer via a start/done handshake.
`default_nettype none

module draw_triangle #(
  parameter logic [9:0] MAX_X = 10'd639,
  parameter logic [9:0] MAX_Y = 10'd479
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_tri_valid,
  output logic       o_tri_ready,
  input  logic [9:0] i_v0x,
  input  logic [9:0] i_v0y,
  input  logic [9:0] i_v1x,
  input  logic [9:0] i_v1y,
  input  logic [9:0] i_v2x,
  input  logic [9:0] i_v2y,
  output logic       o_line_start,
  input  logic       i_line_done,
  output logic [9:0] o_x0,
  output logic [9:0] o_y0,
  output logic [9:0] o_x1,
  output logic [9:0] o_y1,
  output logic [1:0] o_edge_idx,
  output logic       o_busy,
  output logic       o_tri_done
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_GAP   = 3'd3;
  localparam logic [2:0] S_FIN   = 3'd4;

  logic [2:0] r_state;
  logic [2:0] w_next_state;
  logic [9:0] r_v0x, r_v0y, r_v1x, r_v1y, r_v2x, r_v2y;
  logic [9:0] r_x0, r_y0, r_x1, r_y1;
  logic [1:0] r_edge_idx;
  logic       r_line_start;
  logic [9:0] w_ax, w_ay, w_bx, w_by;
  logic       w_degen;

  function automatic logic [9:0] clamp(input logic [9:0] v, input logic [9:0] lim);
    return (v > lim) ? lim : v;
  endfunction

  // Edge endpoint selection: 0 = v0->v1, 1 = v1->v2, 2 = v2->v0
  always_comb begin
    w_ax = r_v2x;
    w_ay = r_v2y;
    w_bx = r_v0x;
    w_by = r_v0y;
    case (r_edge_idx)
      2'd0: begin
        w_ax = r_v0x; w_ay = r_v0y; w_bx = r_v1x; w_by = r_v1y;
      end
      2'd1: begin
        w_ax = r_v1x; w_ay = r_v1y; w_bx = r_v2x; w_by = r_v2y;
      end
      default: ;
    endcase
    w_degen = (w_ax == w_bx) && (w_ay == w_by);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (i_tri_valid) w_next_state = S_SETUP;
      S_SETUP: w_next_state = w_degen ? S_GAP : S_RUN;
      S_RUN:   if (i_line_done) w_next_state = S_GAP;
      S_GAP:   w_next_state = (r_edge_idx == 2'd2) ? S_FIN : S_SETUP;
      S_FIN:   w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    o_tri_ready = (r_state == S_IDLE);
    o_busy      = (r_state != S_IDLE);
    o_tri_done  = (r_state == S_FIN);
  end

  // Datapath: vertex capture, endpoint load, edge counter and registered start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v0x <= '0; r_v0y <= '0; r_v1x <= '0; r_v1y <= '0; r_v2x <= '0; r_v2y <= '0;
      r_x0 <= '0; r_y0 <= '0; r_x1 <= '0; r_y1 <= '0;
      r_edge_idx   <= 2'd0;
      r_line_start <= 1'b0;
    end else begin
      r_line_start <= (w_next_state == S_RUN);
      case (r_state)
        S_IDLE: if (i_tri_valid) begin
          r_v0x <= clamp(i_v0x, MAX_X); r_v0y <= clamp(i_v0y, MAX_Y);
          r_v1x <= clamp(i_v1x, MAX_X); r_v1y <= clamp(i_v1y, MAX_Y);
          r_v2x <= clamp(i_v2x, MAX_X); r_v2y <= clamp(i_v2y, MAX_Y);
        end
        S_SETUP: begin
          r_x0 <= w_ax; r_y0 <= w_ay; r_x1 <= w_bx; r_y1 <= w_by;
        end
        S_GAP: if (r_edge_idx != 2'd2) r_edge_idx <= r_edge_idx + 2'd1;
        S_FIN: r_edge_idx <= 2'd0;
        default: ;
      endcase
    end
  end

  assign o_line_start = r_line_start;
  assign o_x0         = r_x0;
  assign o_y0         = r_y0;
  assign o_x1         = r_x1;
  assign o_y1         = r_y1;
  assign o_edge_idx   = r_edge_idx;

endmodule

`default_nettype wire

// File: tb/tb_draw_triangle.sv
// tb_draw_triangle: directed scenarios for draw_triangle with a delayed-done
// line rasterizer responder and an edge/pulse monitor.
`default_nettype none

module tb_draw_triangle;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_tri_valid = 1'b0;
  logic       o_tri_ready;
  logic [9:0] i_v0x = '0, i_v0y = '0, i_v1x = '0, i_v1y = '0, i_v2x = '0, i_v2y = '0;
  logic       o_line_start;
  logic       i_line_done;
  logic [9:0] o_x0, o_y0, o_x1, o_y1;
  logic [1:0] o_edge_idx;
  logic       o_busy;
  logic       o_tri_done;

  logic resp_done = 1'b0;
  logic stray_done = 1'b0;
  assign i_line_done = resp_done | stray_done;

  draw_triangle dut (
    .clk(clk), .rst_n(rst_n),
    .i_tri_valid(i_tri_valid), .o_tri_ready(o_tri_ready),
    .i_v0x(i_v0x), .i_v0y(i_v0y), .i_v1x(i_v1x), .i_v1y(i_v1y), .i_v2x(i_v2x), .i_v2y(i_v2y),
    .o_line_start(o_line_start), .i_line_done(i_line_done),
    .o_x0(o_x0), .o_y0(o_y0), .o_x1(o_x1), .o_y1(o_y1),
    .o_edge_idx(o_edge_idx), .o_busy(o_busy), .o_tri_done(o_tri_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int resp_delay = 5;
  int run_cnt = 0;
  int rise_cnt, done_cnt, done_cyc, acc_cyc, cur_len, ready_cnt, idx_n;
  logic [9:0] ex0[8], ey0[8], ex1[8], ey1[8];
  logic [1:0] eidx[8], idxlog[8];
  int elen[8], erise[8], efall[8];
  logic prev_start = 1'b0, prev_busy = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor plus rasterizer model: done asserted on the resp_delay-th RUN cycle
  always @(negedge clk) begin
    if (o_busy && !prev_busy) acc_cyc = cyc;
    if (o_line_start && !prev_start && rise_cnt < 8) begin
      ex0[rise_cnt] = o_x0; ey0[rise_cnt] = o_y0;
      ex1[rise_cnt] = o_x1; ey1[rise_cnt] = o_y1;
      eidx[rise_cnt] = o_edge_idx; erise[rise_cnt] = cyc;
      rise_cnt++;
      cur_len = 0;
    end
    if (o_line_start) cur_len++;
    if (!o_line_start && prev_start && rise_cnt > 0) begin
      elen[rise_cnt-1] = cur_len; efall[rise_cnt-1] = cyc;
    end
    if (o_tri_done) begin done_cnt++; done_cyc = cyc; end
    if (o_tri_ready && done_cnt == 1) ready_cnt++;
    if (o_busy && idx_n < 8 && (idx_n == 0 || idxlog[idx_n-1] != o_edge_idx)) begin
      idxlog[idx_n] = o_edge_idx; idx_n++;
    end
    if (o_line_start) begin
      run_cnt++;
      resp_done = (run_cnt >= resp_delay);
    end else begin
      run_cnt = 0;
      resp_done = 1'b0;
    end
    prev_start = o_line_start;
    prev_busy  = o_busy;
  end

  task automatic clear_mon();
    rise_cnt = 0; done_cnt = 0; done_cyc = 0; acc_cyc = 0;
    cur_len = 0; ready_cnt = 0; idx_n = 0;
  endtask

  task automatic drive_verts(input int ax, ay, bx, by, cx, cy);
    i_v0x = ax[9:0]; i_v0y = ay[9:0]; i_v1x = bx[9:0];
    i_v1y = by[9:0]; i_v2x = cx[9:0]; i_v2y = cy[9:0];
  endtask

  // Present one triangle for a single cycle, then scramble the inputs
  task automatic send_tri(input int ax, ay, bx, by, cx, cy);
    @(negedge clk); #1;
    drive_verts(ax, ay, bx, by, cx, cy);
    i_tri_valid = 1'b1;
    @(negedge clk); #1;
    i_tri_valid = 1'b0;
    drive_verts(1023, 1023, 7, 9, 300, 200);
  endtask

  task automatic wait_done(input int n, input int bound);
    for (int i = 0; i < bound && done_cnt < n; i++) begin
      @(negedge clk); #1;
    end
    checks++;
    if (done_cnt < n) begin
      failures++;
      $display("FAIL wait_done: tri_done count %0d, required %0d within %0d cycles", done_cnt, n, bound);
    end
  endtask

  task automatic check_edge(input string nm, input int k, input int ax, ay, bx, by);
    checks++;
    if (ex0[k] !== ax[9:0] || ey0[k] !== ay[9:0] || ex1[k] !== bx[9:0] || ey1[k] !== by[9:0]) begin
      failures++;
      $display("FAIL %s: edge (%0d,%0d)->(%0d,%0d), required (%0d,%0d)->(%0d,%0d)",
               nm, ex0[k], ey0[k], ex1[k], ey1[k], ax, ay, bx, by);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (o_tri_ready !== 1'b1 || o_line_start !== 1'b0 || o_tri_done !== 1'b0 || o_busy !== 1'b0 ||
        o_edge_idx !== 2'd0 || o_x0 !== 10'd0 || o_y0 !== 10'd0 || o_x1 !== 10'd0 || o_y1 !== 10'd0) begin
      failures++;
      $display("FAIL reset_state: ready=%b start=%b done=%b busy=%b idx=%0d xy=%0d,%0d,%0d,%0d required 1,0,0,0,0 and zeros",
               o_tri_ready, o_line_start, o_tri_done, o_busy, o_edge_idx, o_x0, o_y0, o_x1, o_y1);
    end
    #1 rst_n = 1'b1;
  endtask

  task automatic test_normal();
    clear_mon();
    resp_delay = 5;
    send_tri(10, 30, 40, 20, 25, 50);
    wait_done(1, 200);
    repeat (3) @(negedge clk);
    checks++;
    if (rise_cnt !== 3) begin
      failures++;
      $display("FAIL normal_rises: line_start rises %0d, required 3", rise_cnt);
    end
    check_edge("normal_e0", 0, 10, 30, 40, 20);
    check_edge("normal_e1", 1, 40, 20, 25, 50);
    check_edge("normal_e2", 2, 25, 50, 10, 30);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (elen[k] !== 5 || eidx[k] !== k[1:0]) begin
        failures++;
        $display("FAIL normal_run_%0d: start high %0d idx %0d, required 5 idx %0d", k, elen[k], eidx[k], k);
      end
    end
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (erise[k+1] - efall[k] < 1) begin
        failures++;
        $display("FAIL normal_gap_%0d: low cycles %0d, required >=1", k, erise[k+1] - efall[k]);
      end
    end
    checks++;
    if (done_cnt !== 1 || done_cyc - acc_cyc + 1 !== 22) begin
      failures++;
      $display("FAIL normal_done: pulses %0d latency %0d, required 1 and 22", done_cnt, done_cyc - acc_cyc + 1);
    end
  endtask

  task automatic test_degenerate();
    clear_mon();
    send_tri(100, 100, 100, 100, 100, 100);
    wait_done(1, 50);
    checks++;
    if (rise_cnt !== 0 || done_cyc - acc_cyc + 1 !== 7) begin
      failures++;
      $display("FAIL degenerate: rises %0d latency %0d, required 0 and 7", rise_cnt, done_cyc - acc_cyc + 1);
    end
  endtask

  task automatic test_clamp();
    clear_mon();
    resp_delay = 1;
    send_tri(700, 500, 0, 0, 639, 10);
    wait_done(1, 100);
    checks++;
    if (rise_cnt !== 3) begin
      failures++;
      $display("FAIL clamp_rises: line_start rises %0d, required 3", rise_cnt);
    end
    check_edge("clamp_e0", 0, 639, 479, 0, 0);
    check_edge("clamp_e1", 1, 0, 0, 639, 10);
    check_edge("clamp_e2", 2, 639, 10, 639, 479);
    checks++;
    if (elen[0] !== 1 || done_cyc - acc_cyc + 1 !== 10) begin
      failures++;
      $display("FAIL clamp_timing: run len %0d latency %0d, required 1 and 10", elen[0], done_cyc - acc_cyc + 1);
    end
  endtask

  task automatic test_skip_edge();
    clear_mon();
    resp_delay = 3;
    send_tri(5, 5, 5, 5, 50, 5);
    wait_done(1, 100);
    checks++;
    if (rise_cnt !== 2 || eidx[0] !== 2'd1 || eidx[1] !== 2'd2) begin
      failures++;
      $display("FAIL skip_rises: rises %0d idx %0d,%0d, required 2 idx 1,2", rise_cnt, eidx[0], eidx[1]);
    end
    check_edge("skip_e1", 0, 5, 5, 50, 5);
    check_edge("skip_e2", 1, 50, 5, 5, 5);
    checks++;
    if (idx_n !== 3 || idxlog[0] !== 2'd0 || idxlog[1] !== 2'd1 || idxlog[2] !== 2'd2) begin
      failures++;
      $display("FAIL skip_idx_seq: %0d values %0d,%0d,%0d, required 3 values 0,1,2",
               idx_n, idxlog[0], idxlog[1], idxlog[2]);
    end
  endtask

  task automatic test_reset_mid_edge();
    int i;
    clear_mon();
    resp_delay = 100;
    send_tri(10, 30, 40, 20, 25, 50);
    i = 0;
    while (!(o_line_start && o_edge_idx == 2'd1) && i < 200) begin
      @(negedge clk); #1; i++;
    end
    checks++;
    if (i >= 200) begin
      failures++;
      $display("FAIL rst_reach_edge1: edge 1 RUN not reached, idx=%0d start=%b", o_edge_idx, o_line_start);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (o_line_start !== 1'b0 || o_tri_ready !== 1'b1 || o_busy !== 1'b0 || o_edge_idx !== 2'd0 || o_x0 !== 10'd0) begin
      failures++;
      $display("FAIL rst_async: start=%b ready=%b busy=%b idx=%0d x0=%0d, required 0,1,0,0,0",
               o_line_start, o_tri_ready, o_busy, o_edge_idx, o_x0);
    end
    repeat (3) @(negedge clk);
    #1;
    drive_verts(100, 100, 100, 100, 100, 100);
    i_tri_valid = 1'b1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (o_busy !== 1'b1) begin
      failures++;
      $display("FAIL rst_first_accept: busy=%b after first edge, required 1", o_busy);
    end
    @(negedge clk); #1;
    i_tri_valid = 1'b0;
    wait_done(1, 50);
    repeat (2) @(negedge clk);
    checks++;
    if (done_cnt !== 1 || rise_cnt !== 2) begin
      failures++;
      $display("FAIL rst_discard: tri_done %0d rises %0d, required 1 and 2", done_cnt, rise_cnt);
    end
  endtask

  task automatic test_back_to_back();
    clear_mon();
    resp_delay = 2;
    @(negedge clk); #1;
    drive_verts(10, 30, 40, 20, 25, 50);
    i_tri_valid = 1'b1;
    @(negedge clk); #1;
    stray_done = 1'b1;
    @(negedge clk); #1;
    stray_done = 1'b0;
    for (int k = 0; k < 100 && done_cnt < 2; k++) begin
      @(negedge clk); #1;
    end
    i_tri_valid = 1'b0;
    checks++;
    if (done_cnt !== 2) begin
      failures++;
      $display("FAIL b2b_done: tri_done pulses %0d, required 2", done_cnt);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (rise_cnt !== 6 || elen[0] !== 2) begin
      failures++;
      $display("FAIL b2b_stray: rises %0d first run len %0d, required 6 and 2", rise_cnt, elen[0]);
    end
    checks++;
    if (ready_cnt !== 1) begin
      failures++;
      $display("FAIL b2b_ready_gap: ready cycles between triangles %0d, required 1", ready_cnt);
    end
    checks++;
    if (o_busy !== 1'b0 || o_tri_ready !== 1'b1) begin
      failures++;
      $display("FAIL b2b_idle: busy=%b ready=%b, required 0 and 1", o_busy, o_tri_ready);
    end
  endtask

  initial begin
    clear_mon();
    test_reset();
    test_normal();
    test_degenerate();
    test_clamp();
    test_skip_edge();
    test_reset_mid_edge();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
